reflet_boot_loader: RTL and testbench
=====================================

Name: reflet_boot_loader

Overview:
- Parametrised boot sequencer that sits between the controller reset and the CPU.
- Holds the CPU in reset while it receives a program image as a byte stream (normally from the UART RX path), assembles bytes into CPU words of any width, and writes them into instruction RAM.
- Releases the CPU once the image is complete. It replaces the fixed power-on blink bootstrap and lets instruction memory be loaded at run time for any word size or memory depth.

Parameters:
- wordsize, 8: CPU word width in bits (8..64). bytes_per_word = ceil(wordsize/8).
- addr_size, 7: instruction memory address width.
- mem_size, 128: number of instruction words (≤ 2^addr_size, ≤ 65535).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- boot_skip  input  1  when high in WAIT_LEN, skip loading and start the CPU
- rx_data  input  8  received byte
- rx_valid  input  1  one-cycle strobe, rx_data valid
- mem_addr  output  addr_size  instruction RAM write address
- mem_data  output  wordsize  instruction RAM write data
- mem_write_en  output  1  one-cycle write strobe
- cpu_reset  output  1  active-low reset to CPU and peripherals
- busy  output  1  high while loading
- error  output  1  sticky load error

Behaviour:
- Reset (reset=0, asynchronous) forces the following, and applies equally mid-load, where it discards the partial image and restarts at WAIT_LEN:
  - state=WAIT_LEN, cpu_reset=0, busy=1, error=0
  - mem_write_en=0, mem_addr=0, mem_data=0
  - byte_idx=0, word_count=0
- All outputs are registered.
- Image format:
  - 16-bit length L (word count), little-endian, 2 bytes.
  - Then L words, each bytes_per_word bytes, little-endian.
  - Bits beyond wordsize in the last byte of a word are discarded.
- WAIT_LEN:
  - boot_skip=1 (checked before rx_valid) -> RUN.
  - Otherwise collect 2 bytes into L.
  - After the second byte: L=0 -> RUN; L>mem_size -> ERROR; else -> LOAD.
- LOAD:
  - Each rx_valid shifts the byte into word position byte_idx; byte_idx increments.
  - On the last byte of a word, in the next cycle: mem_write_en=1 for exactly one cycle, mem_addr=word_count (truncated to addr_size), mem_data=assembled word. word_count then increments and byte_idx returns to 0.
  - Latency: last byte strobe to write strobe = 1 cycle.
  - Back-to-back rx_valid on consecutive cycles must be accepted with no loss.
  - When word_count reaches L -> RUN (or CHECK if the optional feature is enabled), in the same cycle as the final write strobe.
- RUN:
  - cpu_reset=1, busy=0, mem_write_en=0.
  - rx_valid and boot_skip are ignored until the next reset.
- ERROR:
  - error=1, busy=0, cpu_reset stays 0.
  - All input is ignored until reset.
- rx_valid while mem_write_en is high is still captured; assembly proceeds independently of the write strobe.
- boot_skip is ignored outside WAIT_LEN, and ignored once the first length byte has been received.

Optional Feature:
- Macro: REFLET_BOOT_CHECKSUM_EN.
- When defined:
  - After the final data word, state CHECK receives one more word (bytes_per_word bytes): checksum = sum of all data words mod 2^wordsize.
  - Match -> RUN, one cycle after the last checksum byte.
  - Mismatch -> ERROR.
  - The L=0 image still expects a checksum word, which must equal 0.
  - busy stays high in CHECK.
- When undefined: no CHECK state; LOAD goes directly to RUN.

Test Plan:
- wordsize=8: send bytes 03 00 11 22 33 -> writes (0,0x11),(1,0x22),(2,0x33), each mem_write_en one cycle after its byte; cpu_reset rises with the third write strobe; busy falls.
- wordsize=16: send 02 00 34 12 CD AB -> writes (0,0x1234),(1,0xABCD); wordsize=12 with bytes 01 00 FF FF -> write (0,0xFFF).
- boot_skip=1 right after reset release -> cpu_reset=1 next cycle, no writes; send 00 00 -> RUN, no writes.
- mem_size=128, length 81 00 (129) -> error=1, cpu_reset remains 0, later bytes produce no writes.
- Assert reset low after 2 of 3 words, release, send 01 00 AA -> single write (0,0xAA), then RUN; verify busy=1 and cpu_reset=0 throughout reset.
- With REFLET_BOOT_CHECKSUM_EN, wordsize=8: 02 00 10 20 30 -> RUN; 02 00 10 20 31 -> error=1, cpu_reset=0.

Source files
------------

// File: rtl/reflet_boot_loader.sv
// Boot sequencer: holds the CPU in reset while a byte-stream image is written to instruction RAM.
// Optional trailing checksum word when REFLET_BOOT_CHECKSUM_EN is defined.
module reflet_boot_loader #(
    parameter int wordsize  = 8,
    parameter int addr_size = 7,
    parameter int mem_size  = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 boot_skip,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic [addr_size-1:0] mem_addr,
    output logic [wordsize-1:0]  mem_data,
    output logic                 mem_write_en,
    output logic                 cpu_reset,
    output logic                 busy,
    output logic                 error
);

    localparam int BPW = (wordsize + 7) / 8;
    localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int AW  = BPW * 8;

    typedef enum logic [2:0] {
        S_WAIT_LEN,
        S_LOAD,
`ifdef REFLET_BOOT_CHECKSUM_EN
        S_CHECK,
`endif
        S_RUN,
        S_ERROR
    } state_t;

    // Where the image goes once its data words are in.
`ifdef REFLET_BOOT_CHECKSUM_EN
    localparam state_t S_DONE = S_CHECK;
`else
    localparam state_t S_DONE = S_RUN;
`endif

    state_t               r_state, w_state;
    logic                 r_got_lo, w_got_lo;
    logic [7:0]           r_len_lo, w_len_lo;
    logic [15:0]          r_len, w_len;
    logic [BIW-1:0]       r_byte_idx, w_byte_idx;
    logic [AW-1:0]        r_asm, w_asm;
    logic [15:0]          r_word_count, w_word_count;
    logic                 w_we;
    logic [addr_size-1:0] w_addr;
    logic [wordsize-1:0]  w_data;
    logic [AW-1:0]        w_cur;
    logic                 w_last;
    logic [15:0]          w_len_rx;
`ifdef REFLET_BOOT_CHECKSUM_EN
    logic [wordsize-1:0]  r_sum, w_sum;
`endif

    assign w_len_rx = {rx_data, r_len_lo};
    assign w_last   = (r_byte_idx == BIW'(BPW - 1));

    // Partial word with the incoming byte dropped into its little-endian slot.
    always_comb begin
        w_cur = r_asm;
        for (int i = 0; i < BPW; i++) begin
            if (r_byte_idx == BIW'(i)) begin
                w_cur[8*i +: 8] = rx_data;
            end
        end
    end

    always_comb begin
        w_state      = r_state;
        w_got_lo     = r_got_lo;
        w_len_lo     = r_len_lo;
        w_len        = r_len;
        w_byte_idx   = r_byte_idx;
        w_asm        = r_asm;
        w_word_count = r_word_count;
        w_we         = 1'b0;
        w_addr       = mem_addr;
        w_data       = mem_data;
`ifdef REFLET_BOOT_CHECKSUM_EN
        w_sum        = r_sum;
`endif
        unique case (r_state)
            S_WAIT_LEN: begin
                if (boot_skip && !r_got_lo) begin
                    w_state = S_RUN;
                end else if (rx_valid) begin
                    if (!r_got_lo) begin
                        w_got_lo = 1'b1;
                        w_len_lo = rx_data;
                    end else begin
                        w_len = w_len_rx;
                        if (w_len_rx == 16'd0) begin
                            w_state = S_DONE;
                        end else if ({16'd0, w_len_rx} > 32'(mem_size)) begin
                            w_state = S_ERROR;
                        end else begin
                            w_state = S_LOAD;
                        end
                    end
                end
            end
            S_LOAD: begin
                if (rx_valid) begin
                    if (w_last) begin
                        w_we         = 1'b1;
                        w_addr       = addr_size'(r_word_count);
                        w_data       = w_cur[wordsize-1:0];
                        w_word_count = r_word_count + 16'd1;
                        w_byte_idx   = '0;
                        w_asm        = '0;
`ifdef REFLET_BOOT_CHECKSUM_EN
                        w_sum        = r_sum + w_cur[wordsize-1:0];
`endif
                        if (r_word_count + 16'd1 == r_len) begin
                            w_state = S_DONE;
                        end
                    end else begin
                        w_asm      = w_cur;
                        w_byte_idx = r_byte_idx + BIW'(1);
                    end
                end
            end
`ifdef REFLET_BOOT_CHECKSUM_EN
            S_CHECK: begin
                if (rx_valid) begin
                    if (w_last) begin
                        w_byte_idx = '0;
                        w_asm      = '0;
                        w_state    = (w_cur[wordsize-1:0] == r_sum) ? S_RUN : S_ERROR;
                    end else begin
                        w_asm      = w_cur;
                        w_byte_idx = r_byte_idx + BIW'(1);
                    end
                end
            end
`endif
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_WAIT_LEN;
            r_got_lo     <= 1'b0;
            r_len_lo     <= '0;
            r_len        <= '0;
            r_byte_idx   <= '0;
            r_asm        <= '0;
            r_word_count <= '0;
            mem_write_en <= 1'b0;
            mem_addr     <= '0;
            mem_data     <= '0;
            cpu_reset    <= 1'b0;
            busy         <= 1'b1;
            error        <= 1'b0;
`ifdef REFLET_BOOT_CHECKSUM_EN
            r_sum        <= '0;
`endif
        end else begin
            r_state      <= w_state;
            r_got_lo     <= w_got_lo;
            r_len_lo     <= w_len_lo;
            r_len        <= w_len;
            r_byte_idx   <= w_byte_idx;
            r_asm        <= w_asm;
            r_word_count <= w_word_count;
            mem_write_en <= w_we;
            mem_addr     <= w_addr;
            mem_data     <= w_data;
            cpu_reset    <= (w_state == S_RUN);
            busy         <= (w_state != S_RUN) && (w_state != S_ERROR);
            error        <= (w_state == S_ERROR);
`ifdef REFLET_BOOT_CHECKSUM_EN
            r_sum        <= w_sum;
`endif
        end
    end

endmodule

// File: tb/tb_reflet_boot_loader.sv
// Bench for reflet_boot_loader: three word widths (8, 16, 12) fed the same byte stream,
// each checked against an image-parsing reference model.
module tb_reflet_boot_loader;

    typedef logic [7:0]  bq_t[$];
    typedef logic [79:0] wr_t;

    localparam int ST_BUSY = 0;
    localparam int ST_RUN  = 1;
    localparam int ST_ERR  = 2;
`ifdef REFLET_BOOT_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       boot_skip = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;

    logic [6:0]  a8, a16, a12;
    logic [7:0]  d8;
    logic [15:0] d16;
    logic [11:0] d12;
    logic        we [3];
    logic        cr [3];
    logic        bs [3];
    logic        er [3];

    int checks = 0;
    int errors = 0;

    wr_t got0[$], got1[$], got2[$];
    wr_t exp_q[$];

    always #5 clk = ~clk;

    reflet_boot_loader #(.wordsize(8), .addr_size(7), .mem_size(128)) u8 (
        .clk(clk), .reset(reset), .boot_skip(boot_skip),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .mem_addr(a8), .mem_data(d8), .mem_write_en(we[0]),
        .cpu_reset(cr[0]), .busy(bs[0]), .error(er[0]));

    reflet_boot_loader #(.wordsize(16), .addr_size(7), .mem_size(128)) u16 (
        .clk(clk), .reset(reset), .boot_skip(boot_skip),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .mem_addr(a16), .mem_data(d16), .mem_write_en(we[1]),
        .cpu_reset(cr[1]), .busy(bs[1]), .error(er[1]));

    reflet_boot_loader #(.wordsize(12), .addr_size(7), .mem_size(128)) u12 (
        .clk(clk), .reset(reset), .boot_skip(boot_skip),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .mem_addr(a12), .mem_data(d12), .mem_write_en(we[2]),
        .cpu_reset(cr[2]), .busy(bs[2]), .error(er[2]));

    always @(negedge clk) begin
        if (we[0]) got0.push_back({16'(a8), 64'(d8)});
        if (we[1]) got1.push_back({16'(a16), 64'(d16)});
        if (we[2]) got2.push_back({16'(a12), 64'(d12)});
    end

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ws_of(input int i);
        return (i == 0) ? 8 : (i == 1) ? 16 : 12;
    endfunction

    function automatic int got_n(input int i);
        return (i == 0) ? got0.size() : (i == 1) ? got1.size() : got2.size();
    endfunction

    function automatic wr_t got_at(input int i, input int k);
        return (i == 0) ? got0[k] : (i == 1) ? got1[k] : got2[k];
    endfunction

    function automatic bq_t mkq(input int n, input logic [127:0] v);
        bq_t q;
        for (int k = 0; k < n; k++) q.push_back(v[8*k +: 8]);
        return q;
    endfunction

    // Parses the image as a host would: length, words, optional checksum.
    task automatic model(input bq_t b, input bit skip, input int ws, output int st);
        int bpw, n, len, base;
        logic [63:0] mask, w, sum;
        bpw = (ws + 7) / 8;
        n = b.size();
        mask = (ws == 64) ? '1 : ((64'd1 << ws) - 64'd1);
        sum = '0;
        exp_q.delete();
        st = ST_BUSY;
        if (skip) begin
            st = ST_RUN;
            return;
        end
        if (n < 2) return;
        len = int'(b[0]) + 256 * int'(b[1]);
        if (len > 128) begin
            st = ST_ERR;
            return;
        end
        for (int k = 0; k < len; k++) begin
            if (2 + (k + 1) * bpw > n) return;
            w = '0;
            for (int j = 0; j < bpw; j++) w = w | (64'(b[2 + k*bpw + j]) << (8*j));
            w = w & mask;
            sum = (sum + w) & mask;
            exp_q.push_back({16'(k % 128), w});
        end
        if (CK) begin
            if (2 + (len + 1) * bpw > n) return;
            base = 2 + len * bpw;
            w = '0;
            for (int j = 0; j < bpw; j++) w = w | (64'(b[base + j]) << (8*j));
            st = ((w & mask) == sum) ? ST_RUN : ST_ERR;
        end else begin
            st = ST_RUN;
        end
    endtask

    task automatic do_reset(input string name);
        #2;
        reset = 1'b0;
        boot_skip = 1'b0;
        rx_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk({name, "/rst_cpu"}, 80'(cr[i]), 80'd0);
                chk({name, "/rst_busy"}, 80'(bs[i]), 80'd1);
                chk({name, "/rst_err"}, 80'(er[i]), 80'd0);
                chk({name, "/rst_we"}, 80'(we[i]), 80'd0);
            end
            chk({name, "/rst_addr_data"}, {a8, d8, d16, d12}, 80'd0);
        end
        got0.delete();
        got1.delete();
        got2.delete();
        reset = 1'b1;
    endtask

    task automatic run_case(input string name, input bq_t b, input int skip_at, input bit b2b);
        int st, m;
        do_reset(name);
        for (int k = 0; k < b.size(); k++) begin
            if (skip_at == k) begin
                boot_skip = 1'b1;
                @(negedge clk);
                boot_skip = 1'b0;
                if (k == 0)
                    for (int i = 0; i < 3; i++) chk({name, "/skip_cpu"}, 80'(cr[i]), 80'd1);
            end
            rx_data = b[k];
            rx_valid = 1'b1;
            @(negedge clk);
            rx_valid = 1'b0;
            if (!b2b) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            model(b, skip_at == 0, ws_of(i), st);
            chk({name, "/nwrites"}, 80'(got_n(i)), 80'(exp_q.size()));
            m = (got_n(i) < exp_q.size()) ? got_n(i) : exp_q.size();
            for (int k = 0; k < m; k++) chk({name, "/write"}, got_at(i, k), exp_q[k]);
            chk({name, "/cpu_reset"}, 80'(cr[i]), 80'(st == ST_RUN));
            chk({name, "/busy"}, 80'(bs[i]), 80'(st == ST_BUSY));
            chk({name, "/error"}, 80'(er[i]), 80'(st == ST_ERR));
        end
    endtask

    bq_t q;
    logic [7:0] sb, lat_v;
    int len;

    initial begin
        // Latency: each write strobe follows its byte by one cycle, back-to-back.
        do_reset("lat");
        q = mkq(5, 128'h33_22_11_00_03);
        for (int k = 0; k < 5; k++) begin
            rx_data = q[k];
            rx_valid = 1'b1;
            @(negedge clk);
            if (k >= 2) begin
                lat_v = q[k];
                chk("lat/we", 80'(we[0]), 80'd1);
                chk("lat/addr", 80'(a8), 80'(k - 2));
                chk("lat/data", 80'(d8), 80'(lat_v));
                chk("lat/cpu", 80'(cr[0]), 80'(k == 4 && !CK));
                chk("lat/busy", 80'(bs[0]), 80'(!(k == 4 && !CK)));
            end
        end
        rx_valid = 1'b0;
        @(negedge clk);
        chk("lat/we_drop", 80'(we[0]), 80'd0);

        run_case("w8_basic", mkq(5, 128'h33_22_11_00_03), -1, 1'b1);
        run_case("w16_basic", mkq(6, 128'hAB_CD_12_34_00_02), -1, 1'b1);
        run_case("w12_mask", mkq(4, 128'hFF_FF_00_01), -1, 1'b0);
        run_case("skip", mkq(2, 128'h00_00), 0, 1'b1);
        run_case("len0", mkq(2, 128'h00_00), -1, 1'b1);
        run_case("len0_ck", mkq(4, 128'h00_00_00_00), -1, 1'b1);
        run_case("skip_late", mkq(7, 128'h05_04_03_02_01_00_05), 1, 1'b1);
        run_case("too_long", mkq(5, 128'h33_22_11_00_81), -1, 1'b1);
        run_case("partial", mkq(4, 128'hBB_AA_00_03), -1, 1'b1);
        run_case("after_rst", mkq(3, 128'hAA_00_01), -1, 1'b0);
        run_case("ck_good", mkq(5, 128'h30_20_10_00_02), -1, 1'b1);
        run_case("ck_bad", mkq(5, 128'h31_20_10_00_02), -1, 1'b1);

        for (int r = 0; r < 8; r++) begin
            q.delete();
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(129, 200) : $urandom_range(0, 6);
            q.push_back(8'(len));
            q.push_back(8'(len >> 8));
            sb = 8'h00;
            for (int k = 0; k < 2 * len + 2 && k < 16; k++) begin
                q.push_back(8'($urandom));
                if (k < len) sb = sb + q[2 + k];
            end
            if (len <= 6 && $urandom_range(0, 1) == 1) q[2 + len] = sb;
            run_case("random", q, -1, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
